// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg: shared UART clocking constants, default baud divisor, FSM states.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

    localparam int unsigned CLOCK_RATE      = 50_000_000;
    localparam int unsigned BAUD_RATE       = 115_200;
    localparam int unsigned BAUD_OVERSAMPLE = 16;
    localparam int unsigned BAUD_FRAC_BITS  = 4;

    // Divisor in 1/2^BAUD_FRAC_BITS cycle units, rounded to nearest.
    localparam int unsigned BAUD_DIV_FIXED =
        (CLOCK_RATE * (2 ** BAUD_FRAC_BITS) + (BAUD_RATE * BAUD_OVERSAMPLE) / 2)
        / (BAUD_RATE * BAUD_OVERSAMPLE);

    localparam int unsigned BAUD_DEFAULT_DIV_INT  = BAUD_DIV_FIXED >> BAUD_FRAC_BITS;
    localparam int unsigned BAUD_DEFAULT_DIV_FRAC = BAUD_DIV_FIXED % (2 ** BAUD_FRAC_BITS);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PENDING = 2'd2
    } baud_state_e;

endpackage

`default_nettype wire

// File: rtl/baud_frac_counter.sv
// ----------------------------------------------------------------------------
// baud_frac_counter: cycle counter with fractional accumulator, emits rx tick.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module baud_frac_counter
    import uart_pkg::*;
#(
    parameter int unsigned DIV_INT_W  = 16,
    parameter int unsigned DIV_FRAC_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_i,
    input  logic                  acc_clear_i,
    input  logic [DIV_INT_W-1:0]  div_int_i,
    input  logic [DIV_FRAC_W-1:0] div_frac_i,
    output logic                  tick_next_o,
    output logic                  rx_tick_o
);

    logic [DIV_INT_W-1:0]  cnt_q, cnt_d;
    logic [DIV_FRAC_W-1:0] acc_q, acc_d;
    logic                  tick_q;
    logic [DIV_INT_W-1:0]  div_eff;
    logic [DIV_FRAC_W:0]   acc_sum;
    logic [DIV_INT_W:0]    period;
    logic [DIV_INT_W:0]    cnt_inc;
    logic                  tick_next;

    // The carry of the pending accumulation stretches the period that is
    // currently being counted, so the first period after a clear is exactly D.
    always_comb begin
        div_eff = div_int_i;
        if (div_int_i == '0) begin
            div_eff = DIV_INT_W'(1);
        end
        acc_sum   = {1'b0, acc_q} + {1'b0, div_frac_i};
        period    = {1'b0, div_eff} + {{DIV_INT_W{1'b0}}, acc_sum[DIV_FRAC_W]};
        cnt_inc   = {1'b0, cnt_q} + {{DIV_INT_W{1'b0}}, 1'b1};
        tick_next = !clear_i && (cnt_inc >= period);

        cnt_d = cnt_q;
        acc_d = acc_q;
        if (clear_i) begin
            cnt_d = '0;
            acc_d = '0;
        end else begin
            if (tick_next) begin
                cnt_d = '0;
                acc_d = acc_sum[DIV_FRAC_W-1:0];
            end else begin
                cnt_d = cnt_inc[DIV_INT_W-1:0];
            end
            if (acc_clear_i) begin
                acc_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            acc_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            tick_q <= tick_next;
        end
    end

    assign tick_next_o = tick_next;
    assign rx_tick_o   = tick_q;

endmodule

`default_nettype wire

// File: rtl/baud_tick_generator.sv
// ----------------------------------------------------------------------------
// baud_tick_generator: programmable rx/tx baud strobes with glitch-free reload.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module baud_tick_generator
    import uart_pkg::*;
#(
    parameter int unsigned DIV_INT_W        = 16,
    parameter int unsigned DIV_FRAC_W       = 4,
    parameter int unsigned OVERSAMPLE       = 16,
    parameter int unsigned DEFAULT_DIV_INT  = BAUD_DEFAULT_DIV_INT,
    parameter int unsigned DEFAULT_DIV_FRAC = BAUD_DEFAULT_DIV_FRAC
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  cfg_valid,
    input  logic [DIV_INT_W-1:0]  cfg_div_int,
    input  logic [DIV_FRAC_W-1:0] cfg_div_frac,
    output logic                  cfg_ready,
    output logic                  rx_tick,
    output logic                  tx_tick,
    output logic [DIV_INT_W-1:0]  active_div_int,
    output logic [DIV_FRAC_W-1:0] active_div_frac
);

    localparam int unsigned     OS_W   = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0] OS_MAX = OS_W'(OVERSAMPLE - 1);

    baud_state_e           state_q, state_d;
    logic [OS_W-1:0]       os_cnt_q, os_cnt_d;
    logic                  tx_tick_q, tx_tick_d;
    logic                  arm_q, arm_d;
    logic                  ready_q, ready_d;
    logic [DIV_INT_W-1:0]  act_int_q, act_int_d;
    logic [DIV_FRAC_W-1:0] act_frac_q, act_frac_d;
    logic [DIV_INT_W-1:0]  shd_int_q, shd_int_d;
    logic [DIV_FRAC_W-1:0] shd_frac_q, shd_frac_d;

    logic run_clear;
    logic acc_clear;
    logic tick_next;
    logic handshake;

    assign run_clear = !enable || (state_q == ST_IDLE);
    assign handshake = cfg_valid && ready_q;

    baud_frac_counter #(
        .DIV_INT_W  (DIV_INT_W),
        .DIV_FRAC_W (DIV_FRAC_W)
    ) u_frac_counter (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (run_clear),
        .acc_clear_i (acc_clear),
        .div_int_i   (act_int_q),
        .div_frac_i  (act_frac_q),
        .tick_next_o (tick_next),
        .rx_tick_o   (rx_tick)
    );

    always_comb begin
        state_d    = state_q;
        ready_d    = ready_q;
        act_int_d  = act_int_q;
        act_frac_d = act_frac_q;
        shd_int_d  = shd_int_q;
        shd_frac_d = shd_frac_q;
        arm_d      = 1'b0;
        os_cnt_d   = os_cnt_q;
        tx_tick_d  = 1'b0;
        acc_clear  = 1'b0;

        if (run_clear) begin
            os_cnt_d = '0;
        end else if (tick_next) begin
            if (os_cnt_q == OS_MAX) begin
                os_cnt_d  = '0;
                tx_tick_d = 1'b1;
            end else begin
                os_cnt_d = os_cnt_q + OS_W'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (handshake) begin
                    act_int_d  = cfg_div_int;
                    act_frac_d = cfg_div_frac;
                end
                if (enable) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    if (handshake) begin
                        act_int_d  = cfg_div_int;
                        act_frac_d = cfg_div_frac;
                    end
                end else if (handshake) begin
                    shd_int_d  = cfg_div_int;
                    shd_frac_d = cfg_div_frac;
                    ready_d    = 1'b0;
                    state_d    = ST_PENDING;
                end
            end
            ST_PENDING: begin
                // arm only on a tx tick produced after acceptance; apply one cycle later
                arm_d = tx_tick_d;
                if (!enable || arm_q) begin
                    act_int_d  = shd_int_q;
                    act_frac_d = shd_frac_q;
                    ready_d    = 1'b1;
                    arm_d      = 1'b0;
                    acc_clear  = enable;
                    state_d    = enable ? ST_RUN : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            os_cnt_q   <= '0;
            tx_tick_q  <= 1'b0;
            arm_q      <= 1'b0;
            ready_q    <= 1'b1;
            act_int_q  <= DIV_INT_W'(DEFAULT_DIV_INT);
            act_frac_q <= DIV_FRAC_W'(DEFAULT_DIV_FRAC);
            shd_int_q  <= '0;
            shd_frac_q <= '0;
        end else begin
            state_q    <= state_d;
            os_cnt_q   <= os_cnt_d;
            tx_tick_q  <= tx_tick_d;
            arm_q      <= arm_d;
            ready_q    <= ready_d;
            act_int_q  <= act_int_d;
            act_frac_q <= act_frac_d;
            shd_int_q  <= shd_int_d;
            shd_frac_q <= shd_frac_d;
        end
    end

    assign tx_tick         = tx_tick_q;
    assign cfg_ready       = ready_q;
    assign active_div_int  = act_int_q;
    assign active_div_frac = act_frac_q;

endmodule

`default_nettype wire

// File: tb/tb_baud_tick_generator.sv
// ----------------------------------------------------------------------------
// tb_baud_tick_generator: scoreboard bench for baud_tick_generator.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_baud_tick_generator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        cfg_valid;
    logic [15:0] cfg_div_int;
    logic [3:0]  cfg_div_frac;
    logic        cfg_ready;
    logic        rx_tick;
    logic        tx_tick;
    logic [15:0] active_div_int;
    logic [3:0]  active_div_frac;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int base     = 0;
    logic mon_en = 1'b0;
    int exp_rx_q[$];
    int exp_tx_q[$];

    always #5 clk = ~clk;

    baud_tick_generator #(
        .DIV_INT_W        (16),
        .DIV_FRAC_W       (4),
        .OVERSAMPLE       (16),
        .DEFAULT_DIV_INT  (27),
        .DEFAULT_DIV_FRAC (2)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable          (enable),
        .cfg_valid       (cfg_valid),
        .cfg_div_int     (cfg_div_int),
        .cfg_div_frac    (cfg_div_frac),
        .cfg_ready       (cfg_ready),
        .rx_tick         (rx_tick),
        .tx_tick         (tx_tick),
        .active_div_int  (active_div_int),
        .active_div_frac (active_div_frac)
    );

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Monitor: cycle k of a run is the cycle after its k-th rising edge.
    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (mon_en) begin
            if (rx_tick) begin
                if (exp_rx_q.size() == 0) check("rx_extra", cyc - base, -1);
                else                      check("rx_time", cyc - base, exp_rx_q.pop_front());
            end
            if (tx_tick) begin
                if (exp_tx_q.size() == 0) check("tx_extra", cyc - base, -1);
                else                      check("tx_time", cyc - base, exp_tx_q.pop_front());
            end
        end
    end

    task automatic to_cycle(input int k);
        while (cyc - base < k) @(negedge clk);
    endtask

    task automatic begin_run();
        @(negedge clk);
        enable = 1'b1;
        base   = cyc + 1;
        mon_en = 1'b1;
    endtask

    task automatic end_run(input int w);
        to_cycle(w);
        mon_en = 1'b0;
        enable = 1'b0;
        check("rx_left", exp_rx_q.size(), 0);
        check("tx_left", exp_tx_q.size(), 0);
        exp_rx_q.delete();
        exp_tx_q.delete();
        @(negedge clk);
    endtask

    task automatic cfg_idle(input int di, input int df);
        @(negedge clk);
        cfg_valid    = 1'b1;
        cfg_div_int  = di[15:0];
        cfg_div_frac = df[3:0];
        @(negedge clk);
        cfg_valid = 1'b0;
        check("idle_cfg_int", 32'(active_div_int), di);
        check("idle_cfg_frac", 32'(active_div_frac), df);
    endtask

    // Expected tick times straight from the period rule D + carry(acc + frac).
    task automatic push_model(input int d, input int fr, input int w);
        int t;
        int acc;
        int n;
        int deff;
        t = 0; acc = 0; n = 0;
        deff = (d == 0) ? 1 : d;
        while (t + deff <= w) begin
            t   = t + deff + ((acc + fr) / 16);
            acc = (acc + fr) % 16;
            if (t <= w) begin
                n++;
                exp_rx_q.push_back(t);
                if (n % 16 == 0) exp_tx_q.push_back(t);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; cfg_valid = 1'b0;
        cfg_div_int = '0; cfg_div_frac = '0;
        repeat (3) @(negedge clk);
        check("rst_rx", 32'(rx_tick), 0);
        check("rst_tx", 32'(tx_tick), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'(cfg_ready), 1);
        check("rst_div_int", 32'(active_div_int), 27);
        check("rst_div_frac", 32'(active_div_frac), 2);

        // Integer divisor 4
        cfg_idle(4, 0);
        for (int k = 1; 4 * k <= 140; k++) exp_rx_q.push_back(4 * k);
        exp_tx_q.push_back(64);
        exp_tx_q.push_back(128);
        begin_run();
        to_cycle(1);
        check("run_div_int", 32'(active_div_int), 4);
        end_run(140);

        // Fractional 4.5
        cfg_idle(4, 8);
        exp_rx_q.push_back(4);
        exp_rx_q.push_back(9);
        push_model(4, 8, 150);
        void'(exp_rx_q.pop_front());
        void'(exp_rx_q.pop_front());
        if (exp_tx_q.size() > 0) check("model_tx72", exp_tx_q[0], 72);
        begin_run();
        end_run(150);

        // Reprogram 4 -> 6 while running; held valid during PENDING is ignored
        cfg_idle(4, 0);
        for (int k = 1; k <= 16; k++) exp_rx_q.push_back(4 * k);
        for (int t = 70; t <= 170; t += 6) exp_rx_q.push_back(t);
        exp_tx_q.push_back(64);
        exp_tx_q.push_back(160);
        begin_run();
        to_cycle(10);
        check("pre_hs_ready", 32'(cfg_ready), 1);
        cfg_valid = 1'b1; cfg_div_int = 16'd6; cfg_div_frac = 4'd0;
        to_cycle(11);
        check("hs_ready_low", 32'(cfg_ready), 0);
        cfg_div_int = 16'd9;
        to_cycle(20);
        cfg_valid = 1'b0;
        to_cycle(64);
        check("pend_ready", 32'(cfg_ready), 0);
        check("pend_div_int", 32'(active_div_int), 4);
        to_cycle(65);
        check("apply_ready", 32'(cfg_ready), 1);
        check("apply_div_int", 32'(active_div_int), 6);
        end_run(170);

        // Divisor 0 behaves as 1
        cfg_idle(0, 0);
        for (int t = 1; t <= 40; t++) exp_rx_q.push_back(t);
        exp_tx_q.push_back(16);
        exp_tx_q.push_back(32);
        begin_run();
        end_run(40);

        // Enable dropped while PENDING
        cfg_idle(4, 0);
        for (int t = 4; t <= 20; t += 4) exp_rx_q.push_back(t);
        begin_run();
        to_cycle(10);
        cfg_valid = 1'b1; cfg_div_int = 16'd5; cfg_div_frac = 4'd0;
        to_cycle(11);
        cfg_valid = 1'b0;
        to_cycle(20);
        enable = 1'b0;
        to_cycle(21);
        check("drop_rx", 32'(rx_tick), 0);
        check("drop_ready", 32'(cfg_ready), 1);
        check("drop_div_int", 32'(active_div_int), 5);
        end_run(30);
        push_model(5, 0, 30);
        begin_run();
        end_run(30);

        // Asynchronous reset with a pending config
        exp_rx_q.push_back(5);
        exp_rx_q.push_back(10);
        exp_rx_q.push_back(15);
        begin_run();
        to_cycle(10);
        cfg_valid = 1'b1; cfg_div_int = 16'd9; cfg_div_frac = 4'd3;
        to_cycle(11);
        cfg_valid = 1'b0;
        to_cycle(15);
        rst_n = 1'b0; enable = 1'b0; mon_en = 1'b0;
        #1;
        check("arst_rx", 32'(rx_tick), 0);
        check("arst_tx", 32'(tx_tick), 0);
        check("arst_ready", 32'(cfg_ready), 1);
        check("arst_div_int", 32'(active_div_int), 27);
        check("arst_div_frac", 32'(active_div_frac), 2);
        check("arst_rx_left", exp_rx_q.size(), 0);
        exp_rx_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        push_model(27, 2, 440);
        begin_run();
        to_cycle(435);
        check("post_rst_div_int", 32'(active_div_int), 27);
        check("post_rst_ready", 32'(cfg_ready), 1);
        end_run(440);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/baud_tick_generator.md
# baud_tick_generator

Parametrised, runtime-programmable baud tick source for the UART datapath. It replaces free-running toggled baud clocks with single-cycle enable strobes in the board clock domain. A fractional divisor accumulator yields an rx oversample tick, and a tx bit tick is derived every OVERSAMPLE rx ticks. The divisor is reprogrammed through a valid/ready handshake and applied glitch-free on a tx bit boundary.

## Interface
- DIV_INT_W, 16: width of integer divisor part.
- DIV_FRAC_W, 4: width of fractional divisor part (units of 1/2^DIV_FRAC_W cycle).
- OVERSAMPLE, 16: rx ticks per tx tick; must be ≥2.
- DEFAULT_DIV_INT, 27: integer divisor loaded at reset (50 MHz, 115200 baud, 16x).
- DEFAULT_DIV_FRAC, 2: fractional divisor loaded at reset.
- clk  in  1  board clock; only clock.
- rst_n  in  1  reset, asynchronous, active-low.
- enable  in  1  run tick generation; low holds all counters cleared.
- cfg_valid  in  1  new divisor offered.
- cfg_div_int  in  DIV_INT_W  offered integer divisor.
- cfg_div_frac  in  DIV_FRAC_W  offered fractional divisor.
- cfg_ready  out  1  high when a new divisor can be accepted.
- rx_tick  out  1  one-cycle strobe at baud × OVERSAMPLE.
- tx_tick  out  1  one-cycle strobe at baud; coincides with an rx_tick.
- active_div_int  out  DIV_INT_W  divisor currently in use.
- active_div_frac  out  DIV_FRAC_W  fractional divisor currently in use.

## Operation
- Reset values: rx_tick=0, tx_tick=0, cfg_ready=1, active_div_int=DEFAULT_DIV_INT, active_div_frac=DEFAULT_DIV_FRAC. Cycle counter, fractional accumulator, oversample counter and pending flag are all 0.
- Effective integer divisor: D = max(active_div_int, 1). A value of 0 is treated as 1 and is never rejected.
- Period generation:
  - Each rx period lasts D + c cycles.
  - c is the carry out of {c, acc} = acc + active_div_frac, updated at every rx_tick. acc is DIV_FRAC_W bits and wraps modulo 2^DIV_FRAC_W.
  - The average period is therefore exactly D + frac/2^DIV_FRAC_W.
- Oversample counter: runs 0..OVERSAMPLE-1, increments on rx_tick, and wraps to 0. tx_tick is asserted together with the rx_tick on which the counter wraps.
- States:
  - IDLE (enable=0): all counters cleared; no ticks.
  - RUN (enable=1, no pending config).
  - PENDING (enable=1, shadow divisor held, cfg_ready=0).
- Transitions:
  - IDLE→RUN when enable is sampled 1.
  - RUN→PENDING on handshake (cfg_valid & cfg_ready).
  - PENDING→RUN on the first tx_tick strictly after acceptance. The shadow is copied into active_*, acc is cleared, and the new period starts on the next cycle.
  - any→IDLE when enable is sampled 0.
- Handshake in IDLE: accepted with cfg_ready held high; active_* update on the next cycle.
- enable falling while PENDING: the shadow is applied immediately and cfg_ready returns to 1 on the next cycle.
- cfg_valid held without ready: no effect; the offered value is not latched until ready is high.
- rst_n asserted mid-operation: all state returns to reset values asynchronously and the pending shadow is discarded. Release is synchronous to clk.

## Timing
- All outputs are registered; no combinational input→output paths.
- First rx_tick comes D cycles after the first rising edge on which enable is sampled 1 (counting that edge as cycle 0). With frac=0, ticks then repeat every D cycles.
- First tx_tick comes on the OVERSAMPLE-th rx_tick after enable.
- rx_tick and tx_tick are exactly one cycle wide. With D=1 and frac=0, rx_tick stays high continuously (a tick every cycle).
- cfg_ready falls on the cycle after acceptance in RUN. It rises in the cycle following the applying tx_tick.

## Structure
- Shared package uart_pkg holds:
  - CLOCK_RATE and BAUD_RATE constants.
  - Default divisor constants derived from them.
  - The state enum (IDLE/RUN/PENDING).
- One natural sub-module: baud_frac_counter. It implements the cycle counter plus fractional accumulator, takes D, frac and a clear input, and emits rx_tick. The top level adds the oversample counter, the FSM and the config shadow.

## Test plan
- Reset, div_int=4, frac=0, enable=1 → rx_tick at cycles 4, 8, 12, …; tx_tick first at cycle 64, then every 64; active_div_int reads 4.
- div_int=4, frac=8 (0.5) → rx periods alternate 4/5; 16 rx_ticks span exactly 72 cycles; tx_tick every 72.
- Running div_int=4, handshake div_int=6 at cycle 10 → cfg_ready=0 from cycle 11; 4-cycle periods continue until the tx_tick at 64; 6-cycle periods follow; cfg_ready=1 at cycle 65.
- div_int=0, frac=0 → rx_tick high every cycle; tx_tick every 16 cycles.
- enable dropped while PENDING → ticks stop next cycle; active_* take the shadow; cfg_ready=1. Re-enable → first rx_tick after the new D.
- rst_n pulsed low mid-period with a pending config → outputs 0 at once; active_* back to 27/2; cfg_ready=1; shadow discarded.
